// File: rtl/arrow_line_renderer_pkg.sv
// Shared types, default glyph keys and line-geometry helpers for the arrow line renderer.
package arrow_line_pkg;

  localparam int unsigned KEY_W_DEF     = 5;
  localparam logic [4:0]  BLANK_KEY_DEF = 5'h1F;
  localparam logic [4:0]  UP_KEY_DEF    = 5'h0C;
  localparam logic [4:0]  DOWN_KEY_DEF  = 5'h0D;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  typedef enum logic [1:0] {NONE, UP, DOWN} arrow_dir_t;

  // Bits in one pixel row spanning the whole line.
  function automatic int unsigned line_w(input int unsigned num_chars, input int unsigned glyph_w);
    return num_chars * glyph_w;
  endfunction

  // Bits in the complete line bitmap.
  function automatic int unsigned tot_w(input int unsigned num_chars, input int unsigned glyph_w,
                                        input int unsigned glyph_h);
    return num_chars * glyph_w * glyph_h;
  endfunction

endpackage

// File: rtl/arrow_line_renderer_if.sv
// Request inputs and committed-bitmap outputs of the arrow line renderer.
interface arrow_line_renderer_if #(
  parameter int unsigned NUM_CHARS = 10,
  parameter int unsigned GLYPH_W   = 12,
  parameter int unsigned GLYPH_H   = 12
);
  localparam int unsigned TOT = arrow_line_pkg::tot_w(NUM_CHARS, GLYPH_W, GLYPH_H);

  logic           up;
  logic           down;
  logic           frame_tick;
  logic [TOT-1:0] pixel_map;
  logic           map_valid;
  logic           busy;
  logic           done;

  modport master (output up, down, frame_tick, input pixel_map, map_valid, busy, done);
  modport slave  (input up, down, frame_tick, output pixel_map, map_valid, busy, done);
endinterface

// File: rtl/arrow_line_renderer_font_rom.sv
// Combinational glyph generator: blank, up arrow, down arrow, and a box outline for other keys.
// Pixel (r,c) sits at glyph_c[GLYPH_H*GLYPH_W-1 - r*GLYPH_W - c]; row 0 is the top, col 0 the left.
module font_rom import arrow_line_pkg::*; #(
  parameter int unsigned      GLYPH_W   = 12,
  parameter int unsigned      GLYPH_H   = 12,
  parameter int unsigned      KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] BLANK_KEY = KEY_W'(BLANK_KEY_DEF),
  parameter logic [KEY_W-1:0] UP_KEY    = KEY_W'(UP_KEY_DEF),
  parameter logic [KEY_W-1:0] DOWN_KEY  = KEY_W'(DOWN_KEY_DEF)
) (
  input  logic [KEY_W-1:0]           key,
  output logic [GLYPH_W*GLYPH_H-1:0] glyph_c
);

  localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int          HEAD_ROWS  = int'(GLYPH_H / 2);
  localparam int          MID        = int'(GLYPH_W / 2);

  // Arrow = widening triangle head over a two-pixel shaft; the down arrow is the up arrow flipped.
  always_comb begin
    int   rr;
    logic on;
    glyph_c = '0;
    rr      = 0;
    on      = 1'b0;
    for (int r = 0; r < int'(GLYPH_H); r++) begin
      for (int c = 0; c < int'(GLYPH_W); c++) begin
        rr = (key == DOWN_KEY) ? (int'(GLYPH_H) - 1 - r) : r;
        if (key == UP_KEY || key == DOWN_KEY) begin
          if (rr < HEAD_ROWS) on = (c >= MID - 1 - rr) && (c <= MID + rr);
          else                on = (c == MID - 1) || (c == MID);
        end else if (key != BLANK_KEY) begin
          on = (r == 0) || (r == int'(GLYPH_H) - 1) || (c == 0) || (c == int'(GLYPH_W) - 1);
        end else begin
          on = 1'b0;
        end
        glyph_c[GLYPH_BITS - 1 - r * GLYPH_W - c] = on;
      end
    end
  end

endmodule

// File: rtl/arrow_line_renderer.sv
// Arrow text line renderer: fetches one glyph per cycle from a shared font_rom into a shadow
// buffer, then commits the whole line to pixel_map in a single cycle.
// Optional feature macro: ARROW_BLINK_EN (arrow slot blinks every BLINK_FRAMES frame_ticks).
module arrow_line_renderer import arrow_line_pkg::*; #(
  parameter int unsigned      NUM_CHARS  = 10,
  parameter int unsigned      GLYPH_W    = 12,
  parameter int unsigned      GLYPH_H    = 12,
  parameter int unsigned      KEY_W      = KEY_W_DEF,
  parameter int unsigned      ARROW_SLOT = 5,
  parameter logic [KEY_W-1:0] BLANK_KEY  = KEY_W'(BLANK_KEY_DEF),
  parameter logic [KEY_W-1:0] UP_KEY     = KEY_W'(UP_KEY_DEF),
`ifdef ARROW_BLINK_EN
  parameter logic [KEY_W-1:0] DOWN_KEY   = KEY_W'(DOWN_KEY_DEF),
  parameter int unsigned      BLINK_FRAMES = 30
`else
  parameter logic [KEY_W-1:0] DOWN_KEY   = KEY_W'(DOWN_KEY_DEF)
`endif
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  arrow_line_renderer_if.slave  bus
);

  localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int unsigned LINE_W     = line_w(NUM_CHARS, GLYPH_W);
  localparam int unsigned TOT        = tot_w(NUM_CHARS, GLYPH_W, GLYPH_H);
  localparam int unsigned IDX_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  arrow_dir_t            dir_q, dir_c;
  logic [KEY_W-1:0]      latched_key_q, latched_key_d;
  logic                  have_key_q, have_key_d;
  logic                  pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  map_valid_q;
  logic [TOT-1:0]        pixel_map_q;
  logic [GLYPH_BITS-1:0] shadow_q [NUM_CHARS];

  logic [KEY_W-1:0]      dir_key_c, eff_key_c, rom_key_c;
  logic [GLYPH_BITS-1:0] glyph_c;
  logic [TOT-1:0]        map_c;
  logic                  mismatch_c, pending_c, shadow_we_c, commit_c;

  // Requested direction; asserting both inputs keeps the previous direction.
  always_comb begin
    dir_c = dir_q;
    unique case ({bus.up, bus.down})
      2'b10:   dir_c = UP;
      2'b01:   dir_c = DOWN;
      2'b00:   dir_c = NONE;
      default: dir_c = dir_q;
    endcase
  end

  // Glyph key requested for the arrow slot.
  always_comb begin
    dir_key_c = BLANK_KEY;
    unique case (dir_c)
      UP:      dir_key_c = UP_KEY;
      DOWN:    dir_key_c = DOWN_KEY;
      default: dir_key_c = BLANK_KEY;
    endcase
  end

`ifdef ARROW_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_on_q;

  // Frame-tick blink counter; a blank target parks it at count 0, phase on.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (dir_key_c == BLANK_KEY) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (bus.frame_tick) begin
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        phase_on_q  <= ~phase_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Off phase shows a blank arrow slot.
  always_comb eff_key_c = phase_on_q ? dir_key_c : BLANK_KEY;
`else
  logic unused_frame_tick;
  assign unused_frame_tick = bus.frame_tick;

  // Static arrow.
  always_comb eff_key_c = dir_key_c;
`endif

  // A key differing from the one last latched for rendering requests a new render.
  always_comb begin
    mismatch_c = !have_key_q || (eff_key_c != latched_key_q);
    pending_c  = pending_q | mismatch_c;
  end

  // Time-multiplexed font lookup: only the arrow slot uses the latched key.
  always_comb rom_key_c = (idx_q == IDX_W'(ARROW_SLOT)) ? latched_key_q : BLANK_KEY;

  font_rom #(
    .GLYPH_W   (GLYPH_W),
    .GLYPH_H   (GLYPH_H),
    .KEY_W     (KEY_W),
    .BLANK_KEY (BLANK_KEY),
    .UP_KEY    (UP_KEY),
    .DOWN_KEY  (DOWN_KEY)
  ) u_font_rom (
    .key     (rom_key_c),
    .glyph_c (glyph_c)
  );

  // Reassemble shadow glyphs into line rows; char 0 lands in the MSBs of each row.
  always_comb begin
    map_c = '0;
    for (int r = 0; r < int'(GLYPH_H); r++) begin
      for (int k = 0; k < int'(NUM_CHARS); k++) begin
        map_c[TOT - 1 - r * LINE_W - k * GLYPH_W -: GLYPH_W] =
          shadow_q[k][GLYPH_BITS - 1 - r * GLYPH_W -: GLYPH_W];
      end
    end
  end

  // Next-state and next-output logic for the render sequencer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    latched_key_d = latched_key_q;
    have_key_d    = have_key_q;
    pending_d     = pending_c;
    busy_d        = busy_q;
    done_d        = 1'b0;
    shadow_we_c   = 1'b0;
    commit_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_c) begin
          state_d       = FETCH;
          idx_d         = '0;
          latched_key_d = eff_key_c;
          have_key_d    = 1'b1;
          pending_d     = 1'b0;
          busy_d        = 1'b1;
        end
      end
      FETCH: begin
        shadow_we_c = 1'b1;
        if (idx_q == IDX_W'(NUM_CHARS - 1)) state_d = DONE;
        else                                 idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        commit_c = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state, shadow buffer and committed bitmap registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      dir_q         <= NONE;
      latched_key_q <= BLANK_KEY;
      have_key_q    <= 1'b0;
      pending_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      map_valid_q   <= 1'b0;
      pixel_map_q   <= '0;
      for (int k = 0; k < int'(NUM_CHARS); k++) shadow_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dir_q         <= dir_c;
      latched_key_q <= latched_key_d;
      have_key_q    <= have_key_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      if (shadow_we_c) shadow_q[idx_q] <= glyph_c;
      if (commit_c) begin
        pixel_map_q <= map_c;
        map_valid_q <= 1'b1;
      end
    end
  end

  assign bus.pixel_map = pixel_map_q;
  assign bus.map_valid = map_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_arrow_line_renderer.sv
// Scoreboard bench for arrow_line_renderer: stimulus pushes expected line bitmaps, a monitor
// compares them when done pulses; optional blink behaviour follows ARROW_BLINK_EN.
module tb_arrow_line_renderer;

  localparam int N    = 10;
  localparam int GW   = 12;
  localparam int GH   = 12;
  localparam int LW   = N * GW;
  localparam int TOT  = N * GW * GH;
  localparam int SLOT = 5;

  typedef struct {
    logic [TOT-1:0] map;
    int             due;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [TOT-1:0] prev_map = '0;
  int   model_dir = 0;      // 0 blank, 1 up, 2 down
  int   committed_dir = -1; // -1 nothing rendered
  logic [11:0] up_rows [12];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  arrow_line_renderer_if #(.NUM_CHARS(N), .GLYPH_W(GW), .GLYPH_H(GH)) bus ();

`ifdef ARROW_BLINK_EN
  arrow_line_renderer #(.NUM_CHARS(N), .GLYPH_W(GW), .GLYPH_H(GH), .BLINK_FRAMES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus));
`else
  arrow_line_renderer #(.NUM_CHARS(N), .GLYPH_W(GW), .GLYPH_H(GH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus));
`endif

  function automatic void chk_val(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void chk_map(input string name, input logic [TOT-1:0] act,
                                  input logic [TOT-1:0] req);
    logic [GW-1:0] a, e;
    n_checks++;
    if (act !== req) begin
      n_fail++;
      for (int r = GH - 1; r >= 0; r--)
        for (int k = N - 1; k >= 0; k--) begin
          if (act[TOT-1-r*LW-k*GW -: GW] !== req[TOT-1-r*LW-k*GW -: GW]) begin
            a = act[TOT-1-r*LW-k*GW -: GW];
            e = req[TOT-1-r*LW-k*GW -: GW];
          end
        end
      $display("FAIL %s: first differing row got %h expected %h (cycle %0d)", name, a, e, cyc);
    end
  endfunction

  // Reference glyph rows drawn directly as bit pictures (bit 11 = leftmost pixel).
  function automatic logic [GW-1:0] glyph_row(input int dir, input int r);
    if (dir == 1) return up_rows[r];
    if (dir == 2) return up_rows[GH - 1 - r];
    return '0;
  endfunction

  function automatic logic [TOT-1:0] line_map(input int dir);
    logic [TOT-1:0] m;
    m = '0;
    for (int r = 0; r < GH; r++)
      for (int k = 0; k < N; k++)
        m[TOT-1-r*LW-k*GW -: GW] = (k == SLOT) ? glyph_row(dir, r) : '0;
    return m;
  endfunction

  function automatic int next_dir(input bit u, input bit d);
    if (u && !d) return 1;
    if (d && !u) return 2;
    if (!u && !d) return 0;
    return model_dir;
  endfunction

  function automatic void push_exp(input int dir, input int due);
    exp_t e;
    e.map = line_map(dir);
    e.due = due;
    q.push_back(e);
  endfunction

  // Monitor: compare each commit against the scoreboard and police bitmap atomicity.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && bus.done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no render (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk_map("commit_map", bus.pixel_map, e.map);
        if (e.due >= 0) chk_val("done_latency", cyc, e.due);
        chk_val("map_valid_at_done", bus.map_valid, 1);
        chk_val("busy_at_done", bus.busy, 0);
      end
    end
    if (bus.pixel_map !== prev_map)
      chk_val("map_changes_only_on_done", (bus.done || !Reset_n) ? 1 : 0, 1);
    prev_map = bus.pixel_map;
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      @(negedge Clk); #1;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding renders expected 0", q.size());
      q.delete();
    end
  endtask

  // Drive a request from idle; schedule a render if the committed arrow must change.
  task automatic apply(input bit u, input bit d);
    model_dir = next_dir(u, d);
    bus.up = u;
    bus.down = d;
    if (model_dir != committed_dir) begin
      push_exp(model_dir, cyc + N + 2);
      committed_dir = model_dir;
    end
  endtask

  // Change the request k cycles into FETCH (k = N means during DONE).
  task automatic mid_change(input bit u0, input bit d0, input bit u1, input bit d1, input int k);
    int first_due;
    apply(u0, d0);
    first_due = q[q.size()-1].due;
    repeat (1 + k) @(negedge Clk);
    #1;
    model_dir = next_dir(u1, d1);
    bus.up = u1;
    bus.down = d1;
    if (model_dir != committed_dir) begin
      push_exp(model_dir, first_due + N + 2);
      committed_dir = model_dir;
    end
    drain(80);
  endtask

  task automatic idle_no_render(input string name, input int cycles, input int dir);
    int busy_seen;
    busy_seen = 0;
    repeat (cycles) begin
      @(negedge Clk); #1;
      if (bus.busy) busy_seen++;
    end
    chk_val(name, busy_seen, 0);
    chk_map({name, "_map"}, bus.pixel_map, line_map(dir));
  endtask

  initial begin
    up_rows = '{12'h060, 12'h0F0, 12'h1F8, 12'h3FC, 12'h7FE, 12'hFFF,
                12'h060, 12'h060, 12'h060, 12'h060, 12'h060, 12'h060};
    bus.up = 1'b0;
    bus.down = 1'b0;
    bus.frame_tick = 1'b0;
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk_map("reset_pixel_map", bus.pixel_map, '0);
    chk_val("reset_map_valid", bus.map_valid, 0);
    chk_val("reset_busy", bus.busy, 0);
    chk_val("reset_done", bus.done, 0);

    // Reset release renders the blank line.
    model_dir = 0;
    committed_dir = 0;
    push_exp(0, cyc + N + 2);
    Reset_n = 1'b1;
    @(negedge Clk); #1;
    chk_val("busy_after_release", bus.busy, 1);
    chk_val("map_valid_before_commit", bus.map_valid, 0);
    drain(40);

    // Down arrow from idle.
    apply(1'b0, 1'b1);
    @(negedge Clk); #1;
    chk_val("busy_in_fetch", bus.busy, 1);
    drain(40);

    // Change mid-render: current render completes, the new one follows.
    apply(1'b0, 1'b0); drain(40);
    mid_change(1'b0, 1'b1, 1'b1, 1'b0, 3);
    mid_change(1'b0, 1'b1, 1'b0, 0, 0);
    mid_change(1'b1, 1'b0, 1'b0, 1'b1, N);
    for (int i = 0; i < 4; i++) begin
      if (model_dir == 1) mid_change(1'b0, 1'b1, 1'b1, 1'b0, $urandom_range(0, N));
      else                mid_change(1'b1, 1'b0, 1'b0, 1'b1, $urandom_range(0, N));
    end

    // Both inputs high holds the committed up arrow.
    apply(1'b1, 1'b0); drain(40);
    apply(1'b1, 1'b1);
    idle_no_render("hold_both", 20, 1);
    apply(1'b1, 1'b0);
    idle_no_render("hold_then_up", 5, 1);

    // Reset in the middle of a render, then re-render after release.
    apply(1'b0, 1'b1);
    repeat (7) @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    chk_map("midreset_pixel_map", bus.pixel_map, '0);
    chk_val("midreset_map_valid", bus.map_valid, 0);
    chk_val("midreset_busy", bus.busy, 0);
    chk_val("midreset_done", bus.done, 0);
    q.delete();
    repeat (2) @(negedge Clk);
    #1;
    model_dir = next_dir(bus.up, bus.down);
    committed_dir = model_dir;
    push_exp(model_dir, cyc + N + 2);
    Reset_n = 1'b1;
    drain(40);

    // Randomised requests from idle.
    for (int i = 0; i < 30; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain(40);
      repeat ($urandom_range(1, 4)) @(negedge Clk);
      #1;
    end

    // Frame ticks with a down arrow.
    apply(1'b0, 1'b0); drain(40);
    apply(1'b0, 1'b1); drain(40);
`ifdef ARROW_BLINK_EN
    for (int p = 0; p < 4; p++) begin
      bus.frame_tick = 1'b1;
      @(negedge Clk); #1;
      bus.frame_tick = 1'b0;
      repeat (3) @(negedge Clk);
      #1;
      bus.frame_tick = 1'b1;
      committed_dir = (p % 2 == 0) ? 0 : 2;
      push_exp(committed_dir, -1);
      @(negedge Clk); #1;
      bus.frame_tick = 1'b0;
      drain(40);
    end
`else
    for (int p = 0; p < 6; p++) begin
      bus.frame_tick = 1'b1;
      @(negedge Clk); #1;
      bus.frame_tick = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
    end
    idle_no_render("static_arrow", 5, 2);
`endif

    drain(40);
    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected completion within 1 ms");
    $fatal(1);
  end

endmodule
